// File: rtl/jk_pkg.sv
// Shared types and encodings for the JK latch drive encoder.
// Holds FSM states, mode encodings and JK excitation constants.
package jk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } jk_state_e;

  localparam logic MODE_SR  = 1'b0;
  localparam logic MODE_MIN = 1'b1;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

  // Excitation {J,K} that moves a latch believed to hold trk_i to target t_i.
  function automatic logic [1:0] jk_encode(input logic mode_i, input logic t_i,
                                           input logic trk_i);
    logic [1:0] jk;
    if (mode_i == MODE_SR) jk = t_i ? JK_SET : JK_RST;
    else                   jk = (t_i == trk_i) ? JK_HOLD : JK_TOG;
    return jk;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Small show-ahead FIFO holding target bits for the JK drive encoder.
// Pointers wrap naturally because DEPTH is a power of two.
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: reads are gated by the count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/jk_drive_encoder.sv
// Drives an external JK latch from a queue of target bits and checks
// the latch feedback, counting mismatches and resynchronising on error.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_IDLE  | no command in flight, waiting for a queued bit
//   ST_DRIVE | J/K and en_out presented to the latch for one cycle
//   ST_CHECK | q_fb compared with the target at the closing edge
module jk_drive_encoder
  import jk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  input  logic             mode,
  output logic             J,
  output logic             K,
  output logic             en_out,
  output logic             lrst_n,
  input  logic             q_fb,
  input  logic             err_clr,
  output logic             err,
  output logic [CNT_W-1:0] mis_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  jk_state_e        state_q, state_d;
  logic [1:0]       jk_q, jk_d;
  logic             en_q, en_d;
  logic             t_q, t_d;
  logic             trk_q, trk_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lrst_n_q;

  logic             fifo_push, fifo_pop, fifo_dout, fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;

  assign in_ready  = (fifo_count != CW'(DEPTH));
  assign fifo_push = in_valid & ~fifo_full;

  jk_cmd_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(1)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (fifo_push),
    .din_i  (in_bit),
    .pop_i  (fifo_pop),
    .dout_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    trk_d    = trk_q;
    err_d    = err_q & ~err_clr;
    cnt_d    = cnt_q;
    jk_d     = JK_HOLD;
    en_d     = 1'b0;
    fifo_pop = 1'b0;

    case (state_q)
      ST_DRIVE: begin
        state_d = ST_CHECK;
        trk_d   = t_q;
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (q_fb != t_q) begin
          err_d = 1'b1;
          trk_d = q_fb;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Encoding uses trk_d so a back-to-back command sees the resynced state.
    if ((state_q != ST_DRIVE) && !fifo_empty && lrst_n_q) begin
      fifo_pop = 1'b1;
      state_d  = ST_DRIVE;
      t_d      = fifo_dout;
      jk_d     = jk_encode(mode, fifo_dout, trk_d);
      en_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      jk_q     <= JK_HOLD;
      en_q     <= 1'b0;
      t_q      <= 1'b0;
      trk_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      lrst_n_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      jk_q     <= jk_d;
      en_q     <= en_d;
      t_q      <= t_d;
      trk_q    <= trk_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      lrst_n_q <= 1'b1;
    end
  end

  assign J       = jk_q[1];
  assign K       = jk_q[0];
  assign en_out  = en_q;
  assign lrst_n  = lrst_n_q;
  assign err     = err_q;
  assign mis_cnt = cnt_q;

endmodule
